// File: rtl/udm_fpadd_slave.sv
// rtl/udm_fpadd_slave.sv - CSR-mapped multi-cycle single-precision add/sub engine
// Round toward zero, denormals flushed, Inf/NaN operands give canonical NaN.
module udm_fpadd_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h00000100
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        bus_req_i,
  input  logic        bus_we_i,
  input  logic [31:0] bus_addr_bi,
  input  logic [3:0]  bus_be_bi,
  input  logic [31:0] bus_wdata_bi,
  output logic        bus_ack_o,
  output logic        bus_resp_o,
  output logic [31:0] bus_rdata_bo
);

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_PACK
  } state_t;

  state_t      r_state, w_next;

  logic [31:0] r_opa, r_opb, r_result, r_rdata;
  logic        r_sub, r_done, r_nan, r_ovf, r_unf, r_resp;
  logic        r_sa, r_sb, r_sign, r_eq_sign;
  logic [7:0]  r_ea, r_eb, r_exp;
  logic [23:0] r_ma, r_mb;
  logic [24:0] r_sum;

  logic        w_hit, w_wr, w_rd, w_busy, w_start;
  logic [2:0]  w_off;
  logic [31:0] w_rmux;
  logic [7:0]  w_ea, w_eb;
  logic [23:0] w_ma, w_mb;
  logic        w_unp_nan, w_b_big;
  logic [7:0]  w_big_e, w_sml_e, w_d;
  logic [23:0] w_big_m, w_sml_m, w_mb_al;
  logic        w_big_s;
  logic [24:0] w_sum_raw;
  logic        w_add_ovf, w_norm_stay;

  assign w_hit   = bus_req_i && (bus_addr_bi >= BASE_ADDR) &&
                   (bus_addr_bi <= BASE_ADDR + 32'h1F);
  assign w_off   = bus_addr_bi[4:2];
  assign w_wr    = w_hit && bus_we_i;
  assign w_rd    = w_hit && !bus_we_i;
  assign w_busy  = (r_state != S_IDLE);
  assign w_start = w_wr && !w_busy && (w_off == 3'd2) && bus_be_bi[0] && bus_wdata_bi[0];

  assign bus_ack_o    = w_hit;
  assign bus_resp_o   = r_resp;
  assign bus_rdata_bo = r_rdata;

  // Operand decode; a zero exponent flushes the whole operand to zero.
  assign w_ea      = r_opa[30:23];
  assign w_eb      = r_opb[30:23];
  assign w_ma      = (w_ea != 8'd0) ? {1'b1, r_opa[22:0]} : 24'd0;
  assign w_mb      = (w_eb != 8'd0) ? {1'b1, r_opb[22:0]} : 24'd0;
  assign w_unp_nan = (w_ea == 8'hFF) || (w_eb == 8'hFF);

  assign w_b_big   = {r_eb, r_mb} > {r_ea, r_ma};
  assign w_big_e   = w_b_big ? r_eb : r_ea;
  assign w_sml_e   = w_b_big ? r_ea : r_eb;
  assign w_big_m   = w_b_big ? r_mb : r_ma;
  assign w_sml_m   = w_b_big ? r_ma : r_mb;
  assign w_big_s   = w_b_big ? r_sb : r_sa;
  assign w_d       = w_big_e - w_sml_e;
  assign w_mb_al   = (w_d >= 8'd25) ? 24'd0 : (w_sml_m >> w_d);

  assign w_sum_raw   = r_eq_sign ? ({1'b0, r_ma} + {1'b0, r_mb}) : ({1'b0, r_ma} - {1'b0, r_mb});
  assign w_add_ovf   = w_sum_raw[24] && (r_exp == 8'd254);
  assign w_norm_stay = (r_sum != 25'd0) && !r_sum[23] && (r_exp > 8'd1);

  always_comb begin
    w_rmux = 32'd0;
    case (w_off)
      3'd0:    w_rmux = r_opa;
      3'd1:    w_rmux = r_opb;
      3'd3:    w_rmux = {27'd0, r_unf, r_ovf, r_nan, r_done, w_busy};
      3'd4:    w_rmux = r_result;
      default: w_rmux = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_next = S_UNPACK;
      S_UNPACK: w_next = w_unp_nan ? S_PACK : S_ALIGN;
      S_ALIGN:  w_next = S_ADD;
      S_ADD:    w_next = w_add_ovf ? S_PACK : S_NORM;
      S_NORM:   w_next = w_norm_stay ? S_NORM : S_PACK;
      S_PACK:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_opa <= 32'd0;  r_opb <= 32'd0;  r_result <= 32'd0;
      r_sub <= 1'b0;   r_done <= 1'b0;  r_nan <= 1'b0;
      r_ovf <= 1'b0;   r_unf <= 1'b0;
      r_resp <= 1'b0;  r_rdata <= 32'd0;
      r_sa <= 1'b0;    r_sb <= 1'b0;    r_sign <= 1'b0;  r_eq_sign <= 1'b0;
      r_ea <= 8'd0;    r_eb <= 8'd0;    r_exp <= 8'd0;
      r_ma <= 24'd0;   r_mb <= 24'd0;   r_sum <= 25'd0;
    end else begin
      r_resp  <= w_rd;
      r_rdata <= w_rd ? w_rmux : 32'd0;

      if (w_wr && !w_busy) begin
        for (int i = 0; i < 4; i++) begin
          if (bus_be_bi[i] && w_off == 3'd0) r_opa[8*i +: 8] <= bus_wdata_bi[8*i +: 8];
          if (bus_be_bi[i] && w_off == 3'd1) r_opb[8*i +: 8] <= bus_wdata_bi[8*i +: 8];
        end
      end

      if (w_wr && w_off == 3'd3 && bus_be_bi[0] && bus_wdata_bi[1]) r_done <= 1'b0;

      if (w_start) begin
        r_sub  <= bus_wdata_bi[1];
        r_done <= 1'b0;
        r_nan  <= 1'b0;
        r_ovf  <= 1'b0;
        r_unf  <= 1'b0;
      end

      case (r_state)
        S_UNPACK: begin
          if (w_unp_nan) begin
            r_nan  <= 1'b1;
            r_sign <= 1'b0;
            r_exp  <= 8'hFF;
            r_sum  <= 25'h0400000;
          end else begin
            r_sa <= r_opa[31];
            r_sb <= r_opb[31] ^ r_sub;
            r_ea <= w_ea;
            r_eb <= w_eb;
            r_ma <= w_ma;
            r_mb <= w_mb;
          end
        end
        S_ALIGN: begin
          r_ma      <= w_big_m;
          r_mb      <= w_mb_al;
          r_exp     <= w_big_e;
          r_sign    <= w_big_s;
          r_eq_sign <= (r_sa == r_sb);
        end
        S_ADD: begin
          if (w_add_ovf) begin
            r_exp <= 8'hFF;
            r_sum <= 25'd0;
            r_ovf <= 1'b1;
          end else if (w_sum_raw[24]) begin
            r_sum <= w_sum_raw >> 1;
            r_exp <= r_exp + 8'd1;
          end else begin
            r_sum <= w_sum_raw;
          end
        end
        S_NORM: begin
          // Exact cancellation yields +0; running out of exponent yields signed zero.
          if (r_sum == 25'd0) begin
            r_sign <= 1'b0;
            r_exp  <= 8'd0;
          end else if (w_norm_stay) begin
            r_sum <= r_sum << 1;
            r_exp <= r_exp - 8'd1;
          end else if (!r_sum[23]) begin
            r_exp <= 8'd0;
            r_sum <= 25'd0;
            r_unf <= 1'b1;
          end
        end
        S_PACK: begin
          r_result <= {r_sign, r_exp, r_sum[22:0]};
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_udm_fpadd_slave.sv
// tb/tb_udm_fpadd_slave.sv - randomized self-checking bench for udm_fpadd_slave
// Expected results come from an integer-arithmetic model of the simplified FP rules.
module tb_udm_fpadd_slave;

  localparam logic [31:0] BASE = 32'h00000100;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        ack, resp;
  logic [31:0] rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  udm_fpadd_slave #(.BASE_ADDR(BASE)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .bus_req_i(req), .bus_we_i(we), .bus_addr_bi(addr),
    .bus_be_bi(be), .bus_wdata_bi(wdata),
    .bus_ack_o(ack), .bus_resp_o(resp), .bus_rdata_bo(rdata)
  );

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output logic ak, output logic rs);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = a;
    #1 ak = ack;
    @(posedge clk); #1;
    rs = resp; d = rdata;
    req = 1'b0;
  endtask

  // Reference: decode, order by magnitude, truncating align, add, then normalise by leading-one position.
  function automatic void ref_fp(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                 output logic [31:0] res, output logic [2:0] fl, output int lat);
    int ea, eb, e, d, need, p, te;
    longint ma, mb, s, tm;
    logic sa, sb, sg, ts;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = (ea != 0) ? longint'({1'b1, a[22:0]}) : 64'd0;
    mb = (eb != 0) ? longint'({1'b1, b[22:0]}) : 64'd0;
    sa = a[31];
    sb = b[31] ^ sub;
    fl = 3'b000;
    if (ea == 255 || eb == 255) begin
      res = 32'h7FC00000; fl = 3'b001; lat = 3; return;
    end
    if (eb > ea || (eb == ea && mb > ma)) begin
      te = ea; ea = eb; eb = te;
      tm = ma; ma = mb; mb = tm;
      ts = sa; sa = sb; sb = ts;
    end
    d  = ea - eb;
    mb = (d >= 25) ? 64'd0 : (mb >> d);
    s  = (sa == sb) ? ma + mb : ma - mb;
    e  = ea;
    sg = sa;
    if (s >= 64'd16777216) begin
      s = s >> 1;
      e = e + 1;
      if (e == 255) begin
        res = {sg, 8'hFF, 23'd0}; fl = 3'b010; lat = 5; return;
      end
    end
    if (s == 0) begin
      res = 32'd0; lat = 6; return;
    end
    p = 0;
    for (int i = 0; i < 25; i++) if (s[i]) p = i;
    need = 23 - p;
    if (e - need >= 1) begin
      res = {sg, 8'(e - need), 23'(s << need)};
      lat = 6 + need;
    end else begin
      res = {sg, 31'd0}; fl = 3'b100; lat = 5 + e;
    end
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        output logic [31:0] res, output logic [31:0] st, output int lat, output logic busy1);
    logic [31:0] d;
    logic ak, rs;
    bus_wr(BASE + 32'h0, a, 4'hF);
    bus_wr(BASE + 32'h4, b, 4'hF);
    bus_wr(BASE + 32'h8, {30'd0, sub, 1'b1}, 4'h1);
    lat = -1;
    busy1 = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      bus_rd(BASE + 32'hC, d, ak, rs);
      if (j == 1) busy1 = d[0];
      if (d[1]) begin lat = j; break; end
    end
    bus_rd(BASE + 32'hC, st, ak, rs);
    bus_rd(BASE + 32'h10, res, ak, rs);
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [7:0] e;
    int k;
    k = $urandom_range(0, 11);
    if (k == 0)      e = 8'd0;
    else if (k == 1) e = 8'hFF;
    else if (k == 2) e = 8'(254 - $urandom_range(0, 1));
    else if (k == 3) e = 8'($urandom_range(1, 4));
    else             e = 8'($urandom_range(120, 134));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    logic ak, rs;
    for (int i = 0; i < 5; i++) begin
      bus_rd(BASE + 32'(4 * i), d, ak, rs);
      n_cmp++;
      if (d !== 32'd0 || rs !== 1'b1 || ak !== 1'b1) begin
        n_err++;
        $display("FAIL reset_reg%0d: got data=%h resp=%b ack=%b, want 0/1/1", i, d, rs, ak);
      end
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta [5] = '{32'h3F800000, 32'h3FC00000, 32'h3F800001, 32'h7F7FFFFF, 32'h7FC00000};
    logic [31:0] tb [5] = '{32'h40000000, 32'h3FC00000, 32'h3F800000, 32'h7F7FFFFF, 32'h3F800000};
    logic        ts [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] tr [5] = '{32'h40400000, 32'h00000000, 32'h34000000, 32'h7F800000, 32'h7FC00000};
    logic [4:0]  tf [5] = '{5'h02, 5'h02, 5'h02, 5'h0A, 5'h06};
    logic [31:0] res, st, mres;
    logic [2:0]  mfl;
    int lat, mlat;
    logic busy1;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], ts[i], res, st, lat, busy1);
      ref_fp(ta[i], tb[i], ts[i], mres, mfl, mlat);
      n_cmp++;
      if (res !== tr[i] || res !== mres) begin
        n_err++;
        $display("FAIL dir%0d_result: got %h, want %h (model %h)", i, res, tr[i], mres);
      end
      n_cmp++;
      if (st !== {27'd0, tf[i]} || st[4:2] !== mfl) begin
        n_err++;
        $display("FAIL dir%0d_status: got %h, want %h", i, st, {27'd0, tf[i]});
      end
      n_cmp++;
      if (lat !== mlat || busy1 !== 1'b1) begin
        n_err++;
        $display("FAIL dir%0d_latency: got %0d busy=%b, want %0d busy=1", i, lat, busy1, mlat);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, res, st, mres;
    logic [2:0]  mfl;
    logic sub, busy1;
    int lat, mlat;
    for (int i = 0; i < 60; i++) begin
      a = rnd_fp();
      b = ($urandom_range(0, 2) == 0) ? (a ^ 32'($urandom_range(0, 255))) : rnd_fp();
      sub = 1'($urandom);
      run_op(a, b, sub, res, st, lat, busy1);
      ref_fp(a, b, sub, mres, mfl, mlat);
      n_cmp++;
      if (res !== mres || st !== {27'd0, mfl, 2'b10} || lat !== mlat) begin
        n_err++;
        $display("FAIL rand%0d a=%h b=%h sub=%b: got res=%h st=%h lat=%0d, want res=%h st=%h lat=%0d",
                 i, a, b, sub, res, st, lat, mres, {27'd0, mfl, 2'b10}, mlat);
      end
    end
  endtask

  task automatic test_byte_enable();
    logic [31:0] d;
    logic ak, rs;
    bus_wr(BASE + 32'h0, 32'h00000000, 4'hF);
    bus_wr(BASE + 32'h0, 32'hFFFFFFFF, 4'b0101);
    bus_rd(BASE + 32'h0, d, ak, rs);
    n_cmp++;
    if (d !== 32'h00FF00FF) begin
      n_err++;
      $display("FAIL byte_enable_opa: got %h, want 00ff00ff", d);
    end
    bus_wr(BASE + 32'h4, 32'hA5A5A5A5, 4'hF);
    bus_wr(BASE + 32'h4, 32'h12345678, 4'b1000);
    bus_rd(BASE + 32'h4, d, ak, rs);
    n_cmp++;
    if (d !== 32'h12A5A5A5) begin
      n_err++;
      $display("FAIL byte_enable_opb: got %h, want 12a5a5a5", d);
    end
    bus_rd(BASE + 32'h14, d, ak, rs);
    n_cmp++;
    if (d !== 32'd0 || rs !== 1'b1) begin
      n_err++;
      $display("FAIL reserved_read: got %h resp=%b, want 0 resp=1", d, rs);
    end
  endtask

  task automatic test_busy_and_midop_reset();
    logic [31:0] d;
    logic ak, rs;
    bus_wr(BASE + 32'h0, 32'h3F800001, 4'hF);
    bus_wr(BASE + 32'h4, 32'h3F800000, 4'hF);
    bus_wr(BASE + 32'h8, 32'h3, 4'h1);
    bus_wr(BASE + 32'h0, 32'h12345678, 4'hF);
    bus_rd(BASE + 32'h0, d, ak, rs);
    n_cmp++;
    if (d !== 32'h3F800001) begin
      n_err++;
      $display("FAIL busy_write_opa: got %h, want 3f800001", d);
    end
    repeat (5) @(posedge clk);
    #1 rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    bus_rd(BASE + 32'hC, d, ak, rs);
    n_cmp++;
    if (d !== 32'd0) begin
      n_err++;
      $display("FAIL midop_reset_status: got %h, want 0", d);
    end
    repeat (30) @(posedge clk);
    bus_rd(BASE + 32'hC, d, ak, rs);
    n_cmp++;
    if (d !== 32'd0) begin
      n_err++;
      $display("FAIL midop_reset_no_done: got %h, want 0", d);
    end
    bus_rd(BASE + 32'h10, d, ak, rs);
    n_cmp++;
    if (d !== 32'd0) begin
      n_err++;
      $display("FAIL midop_reset_result: got %h, want 0", d);
    end
  endtask

  task automatic test_out_of_window();
    logic [31:0] d;
    logic ak, rs;
    bus_rd(BASE + 32'h20, d, ak, rs);
    n_cmp++;
    if (ak !== 1'b0 || rs !== 1'b0 || d !== 32'd0) begin
      n_err++;
      $display("FAIL oow_high: got ack=%b resp=%b data=%h, want 0/0/0", ak, rs, d);
    end
    bus_rd(BASE - 32'h4, d, ak, rs);
    n_cmp++;
    if (ak !== 1'b0 || rs !== 1'b0 || d !== 32'd0) begin
      n_err++;
      $display("FAIL oow_low: got ack=%b resp=%b data=%h, want 0/0/0", ak, rs, d);
    end
  endtask

  task automatic test_w1c();
    logic [31:0] res, st, d;
    logic ak, rs, busy1;
    int lat;
    run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, res, st, lat, busy1);
    bus_wr(BASE + 32'hC, 32'h2, 4'h1);
    bus_rd(BASE + 32'hC, d, ak, rs);
    n_cmp++;
    if (d !== 32'h8) begin
      n_err++;
      $display("FAIL w1c_done: got %h, want 00000008", d);
    end
    bus_rd(BASE + 32'h10, d, ak, rs);
    n_cmp++;
    if (d !== 32'h7F800000) begin
      n_err++;
      $display("FAIL result_hold: got %h, want 7f800000", d);
    end
  endtask

  initial begin
    rstn = 1'b0; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0; be = 4'h0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    test_reset();
    test_directed();
    test_byte_enable();
    test_w1c();
    test_busy_and_midop_reset();
    test_out_of_window();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
